nco_phase_acc: RTL and testbench

Phase-generation front end of the NCO. It accumulates a frequency control word (FCW) every enabled cycle and adds a phase offset. It presents the truncated phase as an unsigned angle word, where 2^ANG_WIDTH equals one full turn, directly on the CORDIC rotator's angle input. It also supports handshaked FCW updates and a linear frequency sweep (chirp) engine, so the rotator can be driven with tones or chirps without software pacing.

---
 rtl/nco_phase_acc.sv | 123 ++++++++++++
 tb/tb_nco_phase_acc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_acc.sv
// NCO phase accumulator with handshaked FCW load and a linear chirp engine; one-cycle en-to-phase latency.
// Optional NCO_DITHER_EN adds LFSR dither to the truncated phase only. fcw_ready_o is low while sweeping.
module nco_phase_acc #(
  parameter int ACC_WIDTH = 32,
  parameter int ANG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] fcw_i,
  input  logic                 fcw_valid_i,
  output logic                 fcw_ready_o,
  input  logic [ANG_WIDTH-1:0] pho_i,
  input  logic [ACC_WIDTH-1:0] sweep_step_i,
  input  logic [15:0]          sweep_len_i,
  input  logic                 sweep_start_i,
  output logic                 sweep_busy_o,
  output logic [ANG_WIDTH-1:0] phase_o,
  output logic                 phase_valid_o,
  output logic                 wrap_o
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   fcw_cur_q, fcw_cur_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [ANG_WIDTH-1:0]   phase_q, phase_d;
  logic                   phase_valid_q, phase_valid_d;
  logic                   wrap_q, wrap_d;
  logic [ACC_WIDTH:0]     sum;
  logic [ACC_WIDTH-1:0]   ph_src;

`ifdef NCO_DITHER_EN
  localparam int DW = ACC_WIDTH - ANG_WIDTH;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [ACC_WIDTH-1:0] dith;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    for (int i = 0; i < ACC_WIDTH; i++) begin
      dith[i] = (i < DW && i < 16) ? lfsr_q[i % 16] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  // Dither only shapes the truncated phase; acc and the carry stay exact.
  assign ph_src = sum[ACC_WIDTH-1:0] + dith;
`else
  assign ph_src = sum[ACC_WIDTH-1:0];
`endif

  assign sum = {1'b0, acc_q} + {1'b0, fcw_cur_q};

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    fcw_cur_d     = fcw_cur_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;

    if (en) begin
      acc_d         = sum[ACC_WIDTH-1:0];
      phase_d       = ph_src[ACC_WIDTH-1 -: ANG_WIDTH] + pho_i;
      wrap_d        = sum[ACC_WIDTH];
      phase_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fcw_valid_i) fcw_cur_d = fcw_i;
        if (sweep_start_i && sweep_len_i != 16'd0) begin
          cnt_d   = sweep_len_i;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        // The swept FCW takes effect on the next accumulation, like a normal load.
        if (en) begin
          fcw_cur_d = fcw_cur_q + sweep_step_i;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      fcw_cur_q     <= '0;
      cnt_q         <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      fcw_cur_q     <= fcw_cur_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  assign fcw_ready_o   = (state_q == IDLE);
  assign sweep_busy_o  = (state_q == SWEEP);
  assign phase_o       = phase_q;
  assign phase_valid_o = phase_valid_q;
  assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed bench for nco_phase_acc: tone, offset/wrap, sweep, en gating, handshake, reset abort, fine FCW.
module tb_nco_phase_acc;

  logic        clk = 1'b0;
  logic        rst, en, fcw_valid_i, sweep_start_i;
  logic [31:0] fcw_i, sweep_step_i;
  logic [15:0] pho_i, sweep_len_i;
  logic        fcw_ready_o, sweep_busy_o, phase_valid_o, wrap_o;
  logic [15:0] phase_o;

  int total = 0;
  int bad   = 0;

  nco_phase_acc #(.ACC_WIDTH(32), .ANG_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fcw_i(fcw_i), .fcw_valid_i(fcw_valid_i), .fcw_ready_o(fcw_ready_o),
    .pho_i(pho_i), .sweep_step_i(sweep_step_i), .sweep_len_i(sweep_len_i),
    .sweep_start_i(sweep_start_i), .sweep_busy_o(sweep_busy_o),
    .phase_o(phase_o), .phase_valid_o(phase_valid_o), .wrap_o(wrap_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] sweep_exp [6];
  int          gate_en   [9];
  int          busy_cnt;
  int          idx;
  logic [15:0] last_ph;

  initial begin
    sweep_exp = '{16'h0000, 16'h0001, 16'h0003, 16'h0006, 16'h000A, 16'h000E};
    gate_en   = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    en = 1'b0; fcw_i = '0; fcw_valid_i = 1'b0; pho_i = '0;
    sweep_step_i = '0; sweep_len_i = '0; sweep_start_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_phase", {16'h0, phase_o}, 32'h0);
    chk("rst_valid", {31'h0, phase_valid_o}, 32'h0);
    chk("rst_wrap",  {31'h0, wrap_o}, 32'h0);
    chk("rst_ready", {31'h0, fcw_ready_o}, 32'h1);
    chk("rst_busy",  {31'h0, sweep_busy_o}, 32'h0);
    rst = 1'b0;

    // Basic tone: 256 updates of 1/256 turn
    fcw_i = 32'h0100_0000; fcw_valid_i = 1'b1;
    tick();
    fcw_valid_i = 1'b0;
    chk("load_no_valid", {31'h0, phase_valid_o}, 32'h0);
    en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk("tone_phase", {16'h0, phase_o}, (i * 32'h100) & 32'hFFFF);
      chk("tone_wrap",  {31'h0, wrap_o}, (i == 256) ? 32'h1 : 32'h0);
      chk("tone_valid", {31'h0, phase_valid_o}, 32'h1);
    end
    en = 1'b0;
    tick();
    chk("hold_valid", {31'h0, phase_valid_o}, 32'h0);
    chk("hold_phase", {16'h0, phase_o}, 32'h0);
    chk("hold_wrap",  {31'h0, wrap_o}, 32'h0);

    // Offset and wrap
    do_reset();
    fcw_i = 32'h4000_0000; fcw_valid_i = 1'b1;
    tick();
    fcw_valid_i = 1'b0; pho_i = 16'h2000; en = 1'b1;
    tick(); chk("ofs_ph1", {16'h0, phase_o}, 32'h6000); chk("ofs_w1", {31'h0, wrap_o}, 32'h0);
    tick(); chk("ofs_ph2", {16'h0, phase_o}, 32'hA000); chk("ofs_w2", {31'h0, wrap_o}, 32'h0);
    tick(); chk("ofs_ph3", {16'h0, phase_o}, 32'hE000); chk("ofs_w3", {31'h0, wrap_o}, 32'h0);
    tick(); chk("ofs_ph4", {16'h0, phase_o}, 32'h2000); chk("ofs_w4", {31'h0, wrap_o}, 32'h1);
    en = 1'b0; pho_i = '0;

    // Ungated sweep: start with FCW load of 0 in the same cycle
    do_reset();
    fcw_i = 32'h0; fcw_valid_i = 1'b1; sweep_step_i = 32'h0001_0000;
    sweep_len_i = 16'd4; sweep_start_i = 1'b1; en = 1'b1;
    tick();
    fcw_valid_i = 1'b0; sweep_start_i = 1'b0;
    chk("sw_accept_busy", {31'h0, sweep_busy_o}, 32'h1);
    chk("sw_accept_ready", {31'h0, fcw_ready_o}, 32'h0);
    busy_cnt = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("sw_phase", {16'h0, phase_o}, {16'h0, sweep_exp[k]});
      if (sweep_busy_o) busy_cnt++;
    end
    chk("sw_busy_cycles", busy_cnt, 32'd4);
    chk("sw_final_fcw", dut.fcw_cur_q, 32'h0004_0000);
    en = 1'b0;

    // Gated sweep: 3 en-low cycles after two sweep steps
    do_reset();
    fcw_i = 32'h0; fcw_valid_i = 1'b1; sweep_start_i = 1'b1; en = 1'b1;
    tick();
    fcw_valid_i = 1'b0; sweep_start_i = 1'b0;
    busy_cnt = sweep_busy_o ? 1 : 0;
    idx = 0; last_ph = phase_o;
    for (int k = 0; k < 9; k++) begin
      en = (gate_en[k] != 0);
      tick();
      if (gate_en[k] != 0) begin
        chk("gt_phase", {16'h0, phase_o}, {16'h0, sweep_exp[idx]});
        chk("gt_valid", {31'h0, phase_valid_o}, 32'h1);
        idx++;
      end else begin
        chk("gt_low_valid", {31'h0, phase_valid_o}, 32'h0);
        chk("gt_low_hold", {16'h0, phase_o}, {16'h0, last_ph});
      end
      last_ph = phase_o;
      if (sweep_busy_o) busy_cnt++;
    end
    chk("gt_busy_cycles", busy_cnt, 32'd7);
    chk("gt_final_fcw", dut.fcw_cur_q, 32'h0004_0000);
    en = 1'b0;

    // Handshake: request held through a sweep is taken on the first IDLE cycle
    do_reset();
    fcw_i = 32'h0; fcw_valid_i = 1'b1; sweep_start_i = 1'b1; en = 1'b1;
    tick();
    sweep_start_i = 1'b0; fcw_i = 32'h1234_5678;
    chk("hs_ready_s0", {31'h0, fcw_ready_o}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("hs_ready", {31'h0, fcw_ready_o}, (k == 4) ? 32'h1 : 32'h0);
    end
    chk("hs_pre_accept", dut.fcw_cur_q, 32'h0004_0000);
    tick();
    fcw_valid_i = 1'b0;
    chk("hs_accepted", dut.fcw_cur_q, 32'h1234_5678);
    en = 1'b0;

    // Zero-length sweep request is ignored
    sweep_len_i = 16'd0; sweep_start_i = 1'b1;
    tick();
    sweep_start_i = 1'b0; sweep_len_i = 16'd4;
    chk("len0_busy", {31'h0, sweep_busy_o}, 32'h0);
    chk("len0_ready", {31'h0, fcw_ready_o}, 32'h1);

    // Reset at the second sweep cycle aborts the sweep
    do_reset();
    fcw_i = 32'h0100_0000; fcw_valid_i = 1'b1; sweep_start_i = 1'b1; en = 1'b1;
    tick();
    fcw_valid_i = 1'b0; sweep_start_i = 1'b0;
    tick();
    chk("ra_mid_phase", {16'h0, phase_o}, 32'h0100);
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    chk("ra_phase", {16'h0, phase_o}, 32'h0);
    chk("ra_valid", {31'h0, phase_valid_o}, 32'h0);
    chk("ra_wrap",  {31'h0, wrap_o}, 32'h0);
    chk("ra_ready", {31'h0, fcw_ready_o}, 32'h1);
    chk("ra_busy",  {31'h0, sweep_busy_o}, 32'h0);

    // Fine FCW: half an LSB per update
    fcw_i = 32'h0000_8000; fcw_valid_i = 1'b1;
    tick();
    fcw_valid_i = 1'b0; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
`ifndef NCO_DITHER_EN
      chk("fine_phase", {16'h0, phase_o}, i / 2);
`else
      chk("fine_phase_near", ((phase_o >= 16'(i / 2 - 1)) && (phase_o <= 16'(i / 2 + 1))) ? 32'h1 : 32'h0, 32'h1);
`endif
    end
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
